snake_mover: RTL and testbench

Game-logic stage between the PS/2 keyboard decoder and the pixel renderer. It holds the snake segment position table and latches direction from decoded key codes. On every Nth frame it advances the snake by one grid cell and detects wall and self collisions. Its segment positions feed the renderer's per-pixel segment match, and its died pulse feeds the game-state FSM.

---
 rtl/snake_pkg.sv | 28 ++
 rtl/snake_tick_div.sv | 40 ++++
 rtl/snake_mover.sv | 120 ++++++++++++
 tb/tb_snake_mover.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants for the snake game-logic stage: the position field layout,
// the direction encoding and the PS/2 set-2 arrow-key make codes.
package snake_pkg;

  localparam int POS_W = 13;
  localparam int X_MSB = 6;
  localparam int X_LSB = 0;
  localparam int Y_MSB = 12;
  localparam int Y_LSB = 7;

  typedef enum logic [1:0] {
    DIR_XP = 2'd0,
    DIR_XN = 2'd1,
    DIR_YP = 2'd2,
    DIR_YN = 2'd3
  } dir_e;

  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_UP    = 8'h75;

  // Opposite directions share bit 1 and differ only in bit 0.
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_tick_div.sv
// Frame-tick divider: counts enabled frame ticks and pulses step on the tick
// that completes a full TICK_DIV period.
module snake_tick_div #(
  parameter int TICK_DIV = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic frame_tick,
  output logic step
);

  localparam int CW = 6;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: combinational blocks assign every output a default first and use
  // blocking '='; that keeps them free of inferred latches.
  always_comb begin
    cnt_d = cnt_q;
    step  = 1'b0;
    if (en && frame_tick) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        step  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: clocked state is updated with non-blocking '<=' only.
  always_ff @(posedge clk) begin
    if (reset || clear) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_mover.sv
// Snake game logic: latches direction from key codes, advances the segment
// table every TICK_DIV frames and flags wall or self collisions.
module snake_mover
  import snake_pkg::*;
#(
  parameter int NUM_SEG  = 4,
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int TICK_DIV = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     key_valid,
  input  logic [7:0]               key_code,
  input  logic                     init,
  input  logic                     pause,
  output logic [NUM_SEG*POS_W-1:0] seg_pos,
  output logic [1:0]               dir,
  output logic                     moved,
  output logic                     died,
  output logic                     dead
);

  localparam logic [X_MSB-X_LSB:0] X_LIM = (X_MSB - X_LSB + 1)'(GRID_W);
  localparam logic [Y_MSB-Y_LSB:0] Y_LIM = (Y_MSB - Y_LSB + 1)'(GRID_H);

  logic [POS_W-1:0] seg_q [NUM_SEG];
  dir_e             dir_q, pend_q;
  logic             moved_q, died_q, dead_q;

  logic             step;
  logic             key_hit;
  dir_e             key_dir;
  logic             key_accept;
  logic [X_MSB-X_LSB:0] next_x;
  logic [Y_MSB-Y_LSB:0] next_y;
  logic [POS_W-1:0] next_head;
  logic             wall_hit, self_hit, collide;

  snake_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk        (clk),
    .reset      (reset),
    .clear      (init),
    .en         (!pause && !dead_q),
    .frame_tick (frame_tick),
    .step       (step)
  );

  always_comb begin
    key_hit = 1'b1;
    key_dir = DIR_XP;
    case (key_code)
      KEY_RIGHT: key_dir = DIR_XP;
      KEY_LEFT:  key_dir = DIR_XN;
      KEY_DOWN:  key_dir = DIR_YP;
      KEY_UP:    key_dir = DIR_YN;
      default:   key_hit = 1'b0;
    endcase
    key_accept = key_valid && key_hit && !is_reverse(key_dir, dir_q);
  end

  // A decrement from 0 wraps to all-ones, which the limit compare treats as a wall.
  always_comb begin
    next_x = seg_q[0][X_MSB:X_LSB];
    next_y = seg_q[0][Y_MSB:Y_LSB];
    case (pend_q)
      DIR_XP: next_x = next_x + 1'b1;
      DIR_XN: next_x = next_x - 1'b1;
      DIR_YP: next_y = next_y + 1'b1;
      DIR_YN: next_y = next_y - 1'b1;
      default: ;
    endcase
    next_head = {next_y, next_x};
    wall_hit  = (next_x >= X_LIM) || (next_y >= Y_LIM);
    self_hit  = 1'b0;
    for (int k = 0; k < NUM_SEG - 1; k++) begin
      if (next_head == seg_q[k]) self_hit = 1'b1;
    end
    collide = wall_hit || self_hit;
  end

  // NOTE: the segment table is small and must hold a defined start position,
  // so it is reset like ordinary registers rather than left as uninitialised storage.
  always_ff @(posedge clk) begin
    if (reset || init) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        seg_q[i] <= {(Y_MSB - Y_LSB + 1)'(0), (X_MSB - X_LSB + 1)'(NUM_SEG - 1 - i)};
      end
      dir_q   <= DIR_XP;
      pend_q  <= DIR_XP;
      moved_q <= 1'b0;
      died_q  <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      moved_q <= step && !collide;
      died_q  <= step && collide;
      if (step) begin
        if (collide) begin
          dead_q <= 1'b1;
        end else begin
          for (int i = NUM_SEG - 1; i > 0; i--) seg_q[i] <= seg_q[i-1];
          seg_q[0] <= next_head;
          dir_q    <= pend_q;
        end
      end
      if (key_accept) pend_q <= key_dir;
    end
  end

  for (genvar g = 0; g < NUM_SEG; g++) begin : g_pack
    assign seg_pos[POS_W*g +: POS_W] = seg_q[g];
  end

  assign dir   = dir_q;
  assign moved = moved_q;
  assign died  = died_q;
  assign dead  = dead_q;

endmodule

// File: tb/tb_snake_mover.sv
// Self-checking bench for snake_mover: a behavioural model pushes the expected
// outputs per cycle into a scoreboard queue, plus directed positional checks.
module tb_snake_mover;

  localparam int NUM_SEG  = 4;
  localparam int GRID_W   = 64;
  localparam int GRID_H   = 48;
  localparam int TICK_DIV = 6;

  logic                  clk = 1'b0;
  logic                  reset, frame_tick, key_valid, init, pause;
  logic [7:0]            key_code;
  logic [NUM_SEG*13-1:0] seg_pos;
  logic [1:0]            dir;
  logic                  moved, died, dead;

  always #5 clk = ~clk;

  snake_mover #(
    .NUM_SEG(NUM_SEG), .GRID_W(GRID_W), .GRID_H(GRID_H), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .init       (init),
    .pause      (pause),
    .seg_pos    (seg_pos),
    .dir        (dir),
    .moved      (moved),
    .died       (died),
    .dead       (dead)
  );

  int checks = 0;
  int failures = 0;
  int moved_seen = 0;
  int died_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  int mx [NUM_SEG];
  int my [NUM_SEG];
  int mdir, mpend, mcnt;
  bit mdead, mmoved, mdied;
  logic [63:0] exp_q [$];

  function automatic logic [NUM_SEG*13-1:0] model_pack();
    logic [NUM_SEG*13-1:0] r;
    for (int i = 0; i < NUM_SEG; i++) r[13*i +: 13] = {6'(my[i]), 7'(mx[i])};
    return r;
  endfunction

  function automatic logic [51:0] p4(input int x0, y0, x1, y1, x2, y2, x3, y3);
    return {6'(y3), 7'(x3), 6'(y2), 7'(x2), 6'(y1), 7'(x1), 6'(y0), 7'(x0)};
  endfunction

  task automatic model_cycle(input bit rst, tk, kv, input logic [7:0] kc, input bit in, ps);
    int od, op, nd, opp, dx, dy, nx, ny;
    bit stp, hit;
    if (rst || in) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        mx[i] = NUM_SEG - 1 - i;
        my[i] = 0;
      end
      mdir = 0; mpend = 0; mcnt = 0;
      mdead = 0; mmoved = 0; mdied = 0;
      return;
    end
    od = mdir; op = mpend;
    mmoved = 0; mdied = 0;
    stp = tk && !ps && !mdead && (mcnt == TICK_DIV - 1);
    if (tk && !ps && !mdead) mcnt = (mcnt + 1) % TICK_DIV;
    if (stp) begin
      dx = 0; dy = 0;
      case (op)
        0: dx = 1;
        1: dx = -1;
        2: dy = 1;
        default: dy = -1;
      endcase
      nx = mx[0] + dx;
      ny = my[0] + dy;
      hit = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
      for (int k = 0; k < NUM_SEG - 1; k++) if (nx == mx[k] && ny == my[k]) hit = 1;
      if (hit) begin
        mdied = 1;
        mdead = 1;
      end else begin
        for (int i = NUM_SEG - 1; i > 0; i--) begin
          mx[i] = mx[i-1];
          my[i] = my[i-1];
        end
        mx[0] = nx; my[0] = ny;
        mdir = op;
        mmoved = 1;
      end
    end
    if (kv) begin
      case (kc)
        8'h74: nd = 0;
        8'h6B: nd = 1;
        8'h72: nd = 2;
        8'h75: nd = 3;
        default: nd = -1;
      endcase
      case (nd)
        0: opp = 1;
        1: opp = 0;
        2: opp = 3;
        default: opp = 2;
      endcase
      if (nd >= 0 && opp != od) mpend = nd;
    end
  endtask

  task automatic cycle(input bit rst, tk, kv, input logic [7:0] kc, input bit in, ps);
    logic [63:0] e;
    reset = rst; frame_tick = tk; key_valid = kv; key_code = kc; init = in; pause = ps;
    model_cycle(rst, tk, kv, kc, in, ps);
    exp_q.push_back(64'({model_pack(), 2'(mdir), mmoved, mdied, mdead}));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb", 64'({seg_pos, dir, moved, died, dead}), e);
    if (moved === 1'b1) moved_seen++;
    if (died === 1'b1) died_seen++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic tick_n(input int n, input bit ps = 0);
    repeat (n) begin
      cycle(0, 1, 0, 8'h00, 0, ps);
      cycle(0, 0, 0, 8'h00, 0, ps);
    end
  endtask

  task automatic key(input logic [7:0] kc);
    cycle(0, 0, 1, kc, 0, 0);
  endtask

  task automatic do_init();
    cycle(0, 0, 0, 8'h00, 1, 0);
  endtask

  int m0, d0;

  initial begin
    reset = 1; frame_tick = 0; key_valid = 0; key_code = 0; init = 0; pause = 0;
    cycle(1, 0, 0, 8'h00, 0, 0);
    cycle(1, 0, 0, 8'h00, 0, 0);
    check("rst_seg", 64'(seg_pos), 64'(p4(3, 0, 2, 0, 1, 0, 0, 0)));
    check("rst_flags", 64'({dir, moved, died, dead}), 64'd0);

    // First step: moved one cycle after the sixth tick
    tick_n(5);
    cycle(0, 1, 0, 8'h00, 0, 0);
    check("step1_moved", 64'(moved), 64'd1);
    check("step1_seg", 64'(seg_pos), 64'(p4(4, 0, 3, 0, 2, 0, 1, 0)));
    idle(1);
    check("step1_pulse", 64'(moved), 64'd0);

    // Reverse key ignored
    key(8'h6B);
    tick_n(TICK_DIV);
    check("rev_ignored", 64'(seg_pos), 64'(p4(5, 0, 4, 0, 3, 0, 2, 0)));
    check("rev_dir", 64'(dir), 64'd0);

    // Last accepted key wins
    key(8'h72);
    key(8'h74);
    tick_n(TICK_DIV);
    check("last_key", 64'(seg_pos), 64'(p4(6, 0, 5, 0, 4, 0, 3, 0)));

    // Up from y=0 hits the top wall
    key(8'h75);
    d0 = died_seen;
    m0 = moved_seen;
    tick_n(TICK_DIV);
    check("top_died", 64'(died_seen - d0), 64'd1);
    check("top_dead", 64'(dead), 64'd1);
    check("top_frozen", 64'(seg_pos), 64'(p4(6, 0, 5, 0, 4, 0, 3, 0)));
    tick_n(20);
    check("dead_nomove", 64'(moved_seen - m0), 64'd0);
    check("dead_nodie", 64'(died_seen - d0), 64'd1);

    // Drive the head to (63,5), then one more +x step hits the right wall
    do_init();
    check("init_clear", 64'({dead, seg_pos}), 64'({1'b0, p4(3, 0, 2, 0, 1, 0, 0, 0)}));
    key(8'h72);
    repeat (5) tick_n(TICK_DIV);
    key(8'h74);
    repeat (60) tick_n(TICK_DIV);
    check("edge_head", 64'(seg_pos[12:0]), 64'({6'd5, 7'd63}));
    check("edge_alive", 64'(dead), 64'd0);
    d0 = died_seen;
    tick_n(TICK_DIV);
    check("right_died", 64'(died_seen - d0), 64'd1);
    check("right_head", 64'(seg_pos[12:0]), 64'({6'd5, 7'd63}));

    // Head moves onto the vacating tail: legal
    do_init();
    key(8'h72);
    tick_n(TICK_DIV);
    key(8'h6B);
    tick_n(TICK_DIV);
    key(8'h75);
    tick_n(TICK_DIV);
    check("tail_loop", 64'(seg_pos), 64'(p4(2, 0, 2, 1, 3, 1, 3, 0)));
    check("tail_alive", 64'(dead), 64'd0);

    // Pause holds the divider count
    do_init();
    m0 = moved_seen;
    tick_n(3);
    tick_n(10, 1);
    check("pause_nomove", 64'(moved_seen - m0), 64'd0);
    tick_n(2);
    check("pause_held", 64'(seg_pos), 64'(p4(3, 0, 2, 0, 1, 0, 0, 0)));
    tick_n(1);
    check("pause_resume", 64'(seg_pos), 64'(p4(4, 0, 3, 0, 2, 0, 1, 0)));

    // Key in the step cycle applies only from the next step
    do_init();
    tick_n(5);
    cycle(0, 1, 1, 8'h72, 0, 0);
    check("keystep_head", 64'(seg_pos[12:0]), 64'({6'd0, 7'd4}));
    tick_n(TICK_DIV);
    check("keystep_next", 64'(seg_pos[12:0]), 64'({6'd1, 7'd4}));

    // init with step in the same cycle: load wins
    do_init();
    tick_n(5);
    cycle(0, 1, 0, 8'h00, 1, 0);
    check("init_step", 64'({moved, dead, seg_pos}), 64'({2'b00, p4(3, 0, 2, 0, 1, 0, 0, 0)}));
    tick_n(TICK_DIV);
    check("init_cnt_clr", 64'(seg_pos), 64'(p4(4, 0, 3, 0, 2, 0, 1, 0)));

    // Reset during the step cycle
    tick_n(5);
    cycle(1, 1, 0, 8'h00, 0, 0);
    check("rst_step", 64'({moved, died, seg_pos}), 64'({2'b00, p4(3, 0, 2, 0, 1, 0, 0, 0)}));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
